// File: rtl/pattern_ddr3_loader_pkg.sv
// pattern_ddr3_loader_pkg: header layout, flag value and loader state encoding
package pattern_ddr3_loader_pkg;
  localparam int H_PIX_MSB      = 255;
  localparam int H_PIX_LSB      = 224;
  localparam int V_PIX_MSB      = 223;
  localparam int V_PIX_LSB      = 192;
  localparam int TOTAL_PIX_MSB  = 191;
  localparam int TOTAL_PIX_LSB  = 160;
  localparam int PAT_NUM_MSB    = 159;
  localparam int PAT_NUM_LSB    = 128;
  localparam int FILL_SIZE_MSB  = 127;
  localparam int FILL_SIZE_LSB  = 96;
  localparam int START_ADDR_MSB = 95;
  localparam int START_ADDR_LSB = 64;
  localparam int END_ADDR_MSB   = 63;
  localparam int END_ADDR_LSB   = 32;
  localparam int RSV_MSB        = 31;
  localparam int RSV_LSB        = 0;
  localparam logic [255:0] FLAG_VALUE = 256'h55;
  localparam int PIX_PER_BEAT = 256;
  typedef enum logic [2:0] {
    IDLE, CLR_FLAG, HEAD_COLLECT, HEAD_WRITE, BODY_COLLECT, BODY_WRITE, SET_FLAG, FAIL
  } state_t;
endpackage

// File: rtl/pattern_ddr3_loader_word_packer.sv
// word_packer_32to256: shifts eight 32-bit words into one 256-bit beat, first word at the MSB
module word_packer_32to256 (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst_n,
  input  logic         i_en,
  input  logic [31:0]  i_data,
  input  logic         i_valid,
  output logic         o_beat_valid,
  output logic [255:0] o_beat_next,
  output logic [255:0] o_beat
);
  logic [2:0]   r_idx;
  logic [255:0] r_sh;
  logic         w_acc;
  assign w_acc        = i_en & i_valid;
  assign o_beat_next  = {r_sh[223:0], i_data};
  assign o_beat_valid = w_acc && r_idx == 3'd7;
  assign o_beat       = r_sh;
  // shift each accepted word in; the index wraps after the eighth word
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n)
    if (!ddr3_emif_rst_n) begin
      r_idx <= '0;
      r_sh  <= '0;
    end else if (w_acc) begin
      r_idx <= r_idx + 3'd1;
      r_sh  <= o_beat_next;
    end
endmodule

// File: rtl/pattern_ddr3_loader.sv
// pattern_ddr3_loader: packs host words into DDR3 beats, bracketed by on-chip flag clear/set writes
module pattern_ddr3_loader
  import pattern_ddr3_loader_pkg::*;
#(
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [10:0]       FLAG_ADDR  = '0,
  parameter logic [255:0]      FLAG_VALUE = pattern_ddr3_loader_pkg::FLAG_VALUE
) (
  input  logic              ddr3_emif_clk,
  input  logic              ddr3_emif_rst_n,
  input  logic              start,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              ddr3_emif_ready,
  output logic              ddr3_emif_write,
  output logic [ADDR_W-1:0] ddr3_emif_addr,
  output logic [255:0]      ddr3_emif_write_data,
  output logic [31:0]       ddr3_emif_byte_enable,
  output logic [4:0]        ddr3_emif_burst_count,
  output logic              onchip_mem_clken,
  output logic              onchip_mem_chip_select,
  output logic              onchip_mem_write,
  output logic [10:0]       onchip_mem_addr,
  output logic [31:0]       onchip_mem_byte_enable,
  output logic [255:0]      onchip_mem_write_data
);
  localparam int PIX_SHIFT = $clog2(PIX_PER_BEAT);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_bpp, r_beat_cnt, w_bpp;
  logic [31:0]       r_pat_left, w_tot, w_pat;
  logic              w_collect, w_wr, w_flag, w_pat_end, w_last, w_top;
  logic              w_beat_valid;
  logic [255:0]      w_beat_next, w_beat;
  word_packer_32to256 u_packer (
    .ddr3_emif_clk  (ddr3_emif_clk),
    .ddr3_emif_rst_n(ddr3_emif_rst_n),
    .i_en           (w_collect),
    .i_data         (s_data),
    .i_valid        (s_valid),
    .o_beat_valid   (w_beat_valid),
    .o_beat_next    (w_beat_next),
    .o_beat         (w_beat)
  );
  assign w_collect = r_state == HEAD_COLLECT || r_state == BODY_COLLECT;
  assign w_wr      = r_state == HEAD_WRITE || r_state == BODY_WRITE;
  assign w_flag    = r_state == CLR_FLAG || r_state == SET_FLAG;
  assign w_tot     = 32'(w_beat_next >> TOTAL_PIX_LSB);
  assign w_pat     = 32'(w_beat_next >> PAT_NUM_LSB);
  assign w_bpp     = w_tot[31:PIX_SHIFT] + 24'(|w_tot[PIX_SHIFT-1:0]);
  assign w_pat_end = r_beat_cnt == r_bpp - 24'd1;
  assign w_last    = w_pat_end && r_pat_left == 32'd1;
  assign w_top     = &r_addr;
  assign s_ready                = w_collect || r_state == FAIL;
  assign busy                   = r_state != IDLE;
  assign done                   = r_state == SET_FLAG;
  assign error                  = r_state == FAIL;
  assign ddr3_emif_write        = w_wr;
  assign ddr3_emif_addr         = w_wr ? r_addr : '0;
  assign ddr3_emif_write_data   = w_wr ? w_beat : '0;
  assign ddr3_emif_byte_enable  = w_wr ? '1 : '0;
  assign ddr3_emif_burst_count  = 5'd1;
  assign onchip_mem_clken       = w_flag;
  assign onchip_mem_chip_select = w_flag;
  assign onchip_mem_write       = w_flag;
  assign onchip_mem_addr        = w_flag ? FLAG_ADDR : '0;
  assign onchip_mem_byte_enable = w_flag ? '1 : '0;
  assign onchip_mem_write_data  = r_state == SET_FLAG ? FLAG_VALUE : '0;
  // state register
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n)
    if (!ddr3_emif_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a bad header or running off the top of DDR3 parks the loader in FAIL
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FAIL:   w_next = start ? CLR_FLAG : r_state;
      CLR_FLAG:     w_next = HEAD_COLLECT;
      HEAD_COLLECT: if (w_beat_valid) w_next = (w_tot == '0 || w_pat == '0) ? FAIL : HEAD_WRITE;
      HEAD_WRITE:   if (ddr3_emif_ready) w_next = w_top ? FAIL : BODY_COLLECT;
      BODY_COLLECT: if (w_beat_valid) w_next = BODY_WRITE;
      BODY_WRITE:   if (ddr3_emif_ready) w_next = w_last ? SET_FLAG : w_top ? FAIL : BODY_COLLECT;
      SET_FLAG:     w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end
  // address and pattern/beat counters, header fields latched as the last header word arrives
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n)
    if (!ddr3_emif_rst_n) begin
      r_addr     <= BASE_ADDR;
      r_bpp      <= '0;
      r_beat_cnt <= '0;
      r_pat_left <= '0;
    end else begin
      if (r_state == CLR_FLAG) r_addr <= BASE_ADDR;
      else if (w_wr && ddr3_emif_ready && !w_top) r_addr <= r_addr + ADDR_W'(1);
      if (r_state == HEAD_COLLECT && w_beat_valid) begin
        r_bpp      <= w_bpp;
        r_pat_left <= w_pat;
        r_beat_cnt <= '0;
      end else if (r_state == BODY_WRITE && ddr3_emif_ready) begin
        r_beat_cnt <= w_pat_end ? '0 : r_beat_cnt + 24'd1;
        if (w_pat_end) r_pat_left <= r_pat_left - 32'd1;
      end
    end
endmodule

// File: doc/pattern_ddr3_loader.md
Name: pattern_ddr3_loader

Overview:
- Loads pattern sets into DDR3 ahead of the pixel-side pattern fetch stage.
- Packs a 32-bit host word stream into 256-bit beats and writes them to DDR3 from address 0. Beat 0 is the pattern header; the remaining beats are the pattern bodies.
- Brackets each load with on-chip memory flag writes, so the fetch stage only sees the DDR3 image as valid once it is complete.

Parameters:
- ADDR_W, 22, DDR3 word address width.
- BASE_ADDR, 0, DDR3 address of the header beat.
- FLAG_ADDR, 0, on-chip memory address of the "loaded" flag.
- FLAG_VALUE, 256'h55, flag word written when a load completes.

Ports:
- ddr3_emif_clk  in  1  clock; every port is synchronous to it.
- ddr3_emif_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle load request; ignored unless the state is IDLE.
- s_data  in  32  host word.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts s_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the flag write is issued.
- error  out  1  sticky; cleared by the next accepted start.
- ddr3_emif_ready  in  1  EMIF ready (inverse of waitrequest).
- ddr3_emif_write  out  1  write request.
- ddr3_emif_addr  out  ADDR_W  beat address.
- ddr3_emif_write_data  out  256  beat data.
- ddr3_emif_byte_enable  out  32  all ones while writing, else 0.
- ddr3_emif_burst_count  out  5  constant 1.
- onchip_mem_clken, onchip_mem_chip_select, onchip_mem_write  out  1 each  flag write strobes.
- onchip_mem_addr  out  11  flag address.
- onchip_mem_byte_enable  out  32  all ones during a flag write.
- onchip_mem_write_data  out  256  flag data.

Behaviour:
- Reset: all outputs 0 except ddr3_emif_burst_count=1. State returns to IDLE. Reset mid-load abandons the load; the flag keeps whatever was last written.
- States: IDLE, CLR_FLAG, HEAD_COLLECT, HEAD_WRITE, BODY_COLLECT, BODY_WRITE, SET_FLAG, FAIL.
- IDLE to CLR_FLAG: on start. Also clears error.
- CLR_FLAG: one cycle; writes FLAG_ADDR with 0 (all onchip strobes=1 for that cycle only). Next state HEAD_COLLECT.
- Packing:
  - s_ready=1 only in the COLLECT states.
  - A word is accepted when s_valid&s_ready.
  - Word k (k=0..7) of a beat goes to bits [255-32k -: 32], i.e. the first word is the MSB.
  - After word 7 is accepted, s_ready drops in the same cycle and the next cycle is the WRITE state.
- Header field order, MSB first: h_pix, v_pix, total_pix, pat_num, fill_size, start_addr, end_addr, rsv.
- At the HEAD_COLLECT to HEAD_WRITE transition, latch:
  - beats_per_pat = total_pix[31:8] + |total_pix[7:0]  (24 bits)
  - pat_left = pat_num
  - beat_cnt = 0
- FAIL entry conditions, checked at that same transition: total_pix==0, or pat_num==0. In that case, go to FAIL instead of HEAD_WRITE.
- WRITE states:
  - Drive write=1, addr, data and byte_enable=all-ones, and hold them stable until ddr3_emif_ready=1.
  - The beat is accepted on the first cycle with write&ready; write drops the next cycle.
  - The header goes to BASE_ADDR. Each accepted beat increments addr by 1.
- After each accepted body beat:
  - If beat_cnt==beats_per_pat-1: beat_cnt=0 and pat_left decrements. If pat_left was 1, go to SET_FLAG; otherwise go to BODY_COLLECT.
  - Otherwise beat_cnt increments and the next state is BODY_COLLECT.
- Address overflow: if a beat is accepted at addr=2^ADDR_W-1 and more beats remain, go to FAIL. The address never wraps.
- SET_FLAG: one-cycle onchip write of FLAG_VALUE to FLAG_ADDR, done=1 in the same cycle, then IDLE.
- FAIL: error=1, s_ready=1 (drains and discards input) until start. start in FAIL behaves as in IDLE. The flag stays 0.
- start in any state other than IDLE/FAIL is ignored.
- Latency: the word-7 accept is at cycle N; write is asserted at N+1. With ready=1, the beat is accepted at N+1.

Decomposition:
- Shared package holds:
  - the header field offsets (H_PIX_MSB … RSV_LSB), shared with the fetch stage;
  - FLAG_VALUE;
  - PIX_PER_BEAT=256.
- Natural sub-module: word_packer_32to256. It owns the word index and the shift register, with an output valid/ready toward the FSM.

Test Plan:
- Header total_pix=512, pat_num=2, ready=1 → beats_per_pat=2. DDR3 writes at addr 0..4 with data matching the packed words. Flag write order: 0, then 'h55; done pulses once.
- total_pix=300, pat_num=1 → beats_per_pat=2. Exactly 3 DDR3 writes, then flag 'h55.
- ready low for 5 cycles on the beat at addr 2 → write/addr/data held constant across the stall. Exactly one write is accepted for that beat, and s_ready stays 0 throughout the stall.
- pat_num=0 → no DDR3 writes after the header is collected. error=1, flag stays 0, input is drained. The next start clears error.
- start pulsed during BODY_COLLECT → ignored; the load completes normally.
- Reset asserted mid-BODY_WRITE → all outputs return to reset values asynchronously and state is IDLE. The following load from start succeeds.
